sobel_stream: RTL and testbench
===============================

# sobel_stream

Streaming, parametrised Sobel edge detector. It accepts one RGB pixel per handshake in raster order, converts it to gray, and holds two rows in line buffers to form a 3x3 window. It emits one edge pixel per input pixel through a valid/ready output, selected by mode: saturated magnitude, binary threshold or gray passthrough. It replaces the frame-buffered detector: no full-frame storage, no fixed 160-pixel stride, and real backpressure.

## Interface
Parameters:
- `IMG_W`, 160, pixels per row (>= 3)
- `IMG_H`, 120, rows per frame (>= 3)
- `PIX_W`, 8, bits per colour channel and per output pixel

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `s_valid` in 1: input pixel valid
- `s_ready` out 1: block can accept an input pixel
- `s_r`, `s_g`, `s_b` in PIX_W each: input colour channels
- `m_valid` out 1: output pixel valid
- `m_ready` in 1: downstream accepts the output pixel
- `m_pix` out PIX_W: edge or gray output pixel
- `m_sof` out 1: marks output pixel (0,0)
- `m_eol` out 1: marks the output pixel in the last column
- `cfg_mode` in 2: 0 = magnitude, 1 = threshold, 2 = gray passthrough, 3 = reserved, behaves as 0
- `cfg_thresh` in PIX_W: threshold for mode 1

## Operation
- Gray conversion: gray = (r>>2)+(r>>5)+(g>>1)+(g>>4)+(b>>4)+(b>>5), computed at PIX_W+1 bits and saturated to PIX_W.
- Input row and column counters advance on each accepted input pixel (s_valid && s_ready) and wrap at IMG_W and IMG_H.
- Two line buffers, each IMG_W deep, plus a 3x3 shift window.
- Output pixel k (raster index) is produced once input pixel k+IMG_W+1 has been accepted.
- Gradients:
  - gx = (p02+2p12+p22) - (p00+2p10+p20)
  - gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Both are signed, PIX_W+3 bits.
- Magnitude: mag = |gx|+|gy| at PIX_W+4 bits, saturated to 2^PIX_W-1.
- Border pixels (row 0, row IMG_H-1, column 0, column IMG_W-1) output 0 in modes 0 and 1. In mode 2 they output their gray value.
- Mode 1: m_pix = all-ones if mag >= cfg_thresh, else 0.
- cfg_mode and cfg_thresh are sampled when input pixel (0,0) is accepted and held for the whole frame.
- State machine:
  - FILL → RUN once IMG_W+1 pixels have been accepted.
  - RUN → FLUSH when the last input pixel of the frame is accepted.
  - FLUSH emits the remaining IMG_W+1 output pixels without input, with s_ready=0.
  - FLUSH → FILL after the last output pixel is accepted.
- Every frame yields exactly IMG_W*IMG_H output pixels, in raster order.

## Timing
- Reset values: m_valid=0, m_pix=0, m_sof=0, m_eol=0, counters=0, state=FILL, output register empty.
- s_ready = (state != FLUSH) && (!m_valid || m_ready). It is combinational and is 1 in the first cycle after reset release.
- Output register is a single stage. In RUN with s_valid=1 and m_ready=1, m_valid rises on the clock edge that accepts input k+IMG_W+1, i.e. one cycle of latency.
- While m_valid=1 and m_ready=0, m_pix, m_sof, m_eol and m_valid hold stable. No input is accepted.
- Throughput is one pixel per cycle with no bubbles in RUN or FLUSH when m_ready=1.
- Simultaneous accept-in and accept-out in the same cycle is legal and required at full rate.
- Frame back-to-back: input (0,0) of the next frame is accepted no earlier than the cycle after FLUSH returns to FILL.
- Reset asserted mid-frame: all state clears asynchronously. The partial frame is discarded. The next accepted pixel is treated as (0,0).
- Line buffer reads are synchronous, one cycle. Read address equals write address, with read-before-write at the same location.

## Structure
- `sobel_pkg`:
  - mode encoding constants
  - FILL/RUN/FLUSH state enum
  - gray-conversion function
  - gradient width localparams derived from PIX_W
- Sub-module `sobel_linebuf`: IMG_W x PIX_W single-clock RAM with read-before-write, instantiated twice. Everything else (counters, window, FSM, arithmetic, output stage) lives in `sobel_stream`.

## Test plan
- Uniform frame: RGB=(128,128,128), mode 0 → all IMG_W*IMG_H outputs are 0; m_sof on the first output, m_eol every IMG_W outputs.
- Vertical step:
  - Stimulus: columns < IMG_W/2 get RGB 0, the rest get 255; gray is 0 and 234.
  - Mode 0 → interior columns IMG_W/2-1 and IMG_W/2 output 255 (gx=936, saturated); all other pixels output 0.
- Same step frame in mode 1:
  - cfg_thresh=255 → step columns output 255.
  - cfg_thresh=0 → every non-border pixel outputs 255.
- Mode 2, RGB=(255,0,0) → every output is 70 (63+7).
- Backpressure: m_ready toggles on a random 50% pattern → output stream is identical to the m_ready=1 run; no pixel dropped or duplicated; outputs stable while stalled.
- Reset mid-frame:
  - Stimulus: rst_n low after 500 inputs, then a full uniform frame.
  - Required: m_valid=0 during reset; s_ready=1 in the first cycle after release; exactly IMG_W*IMG_H outputs, all 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types, mode encodings and gray conversion for the Sobel stream.
package sobel_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] MODE_MAG    = 2'd0;
    localparam logic [1:0] MODE_THRESH = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;

    // Widest channel the gray helper handles; PIX_W must not exceed it.
    localparam int PIX_W_MAX  = 16;
    // Signed gradient needs PIX_W+3 bits, |gx|+|gy| needs PIX_W+4.
    localparam int GRAD_EXTRA = 3;
    localparam int MAG_EXTRA  = 4;

    // Shift-add luma approximation, saturated to pw bits.
    function automatic logic [PIX_W_MAX-1:0] rgb2gray(
        input logic [PIX_W_MAX-1:0] r,
        input logic [PIX_W_MAX-1:0] g,
        input logic [PIX_W_MAX-1:0] b,
        input int                   pw
    );
        logic [PIX_W_MAX:0] s;
        logic [PIX_W_MAX:0] lim;
        s = ({1'b0, r} >> 2) + ({1'b0, r} >> 5) + ({1'b0, g} >> 1)
          + ({1'b0, g} >> 4) + ({1'b0, b} >> 4) + ({1'b0, b} >> 5);
        lim = ((PIX_W_MAX+1)'(1) << pw) - (PIX_W_MAX+1)'(1);
        return (s > lim) ? lim[PIX_W_MAX-1:0] : s[PIX_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// Single-port line buffer: synchronous read of the old word, then write, on en.
module sobel_linebuf #(
    parameter  int DEPTH = 160,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Read-before-write at the shared address; output holds while en is low.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with two line buffers and a one-stage output.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_r,
    input  logic [PIX_W-1:0] s_g,
    input  logic [PIX_W-1:0] s_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_pix,
    output logic             m_sof,
    output logic             m_eol,
    input  logic [1:0]       cfg_mode,
    input  logic [PIX_W-1:0] cfg_thresh
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = PIX_W + 2;
    localparam int GW = PIX_W + GRAD_EXTRA;
    localparam int MW = PIX_W + MAG_EXTRA;

    state_t                     state, state_nxt;
    logic [CW-1:0]              icol, ocol, ptr;
    logic [RW-1:0]              irow, orow;
    logic [1:0]                 mode_q;
    logic [PIX_W-1:0]           thr_q;
    logic                       out_free, acc, adv, emit, out_done, border;
    logic [PIX_W-1:0]           gray_in, pix_edge, pix_new;
    logic [1:0][PIX_W-1:0]      lb_wdata, lb_rdata;
    logic [2:0][1:0][PIX_W-1:0] win;   // [row][0=left,1=centre]
    logic [2:0][PIX_W-1:0]      rcol;  // right column, arrives combinationally
    logic [SW-1:0]              sx_r, sx_l, sy_b, sy_t;
    logic signed [GW-1:0]       gx, gy;
    logic [MW-1:0]              ax, ay, mag;

    assign out_free = !m_valid || m_ready;
    assign s_ready  = (state != FLUSH) && out_free;
    assign acc      = s_valid && s_ready;
    assign out_done = (orow == '0) && (ocol == '0);
    // FLUSH keeps the window moving on zero dummies until every output has left.
    assign adv      = (state == FLUSH) ? (!out_done && out_free) : acc;
    assign emit     = adv && (state != FILL);
    assign gray_in  = (state == FLUSH) ? '0
                    : PIX_W'(rgb2gray(PIX_W_MAX'(s_r), PIX_W_MAX'(s_g), PIX_W_MAX'(s_b), PIX_W));

    // lb0 holds the previous row, lb1 the row before; lb1 is fed from lb0's output.
    assign lb_wdata[0] = gray_in;
    assign lb_wdata[1] = lb_rdata[0];

    // The registered read adds one pixel of delay, so the ring walks IMG_W-1 slots.
    for (genvar i = 0; i < 2; i++) begin : g_lb
        sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb (
            .clk   (clk),
            .en    (adv),
            .addr  (ptr),
            .wdata (lb_wdata[i]),
            .rdata (lb_rdata[i])
        );
    end

    assign rcol[0] = lb_rdata[1];
    assign rcol[1] = lb_rdata[0];
    assign rcol[2] = gray_in;

    assign sx_r = SW'(rcol[0])   + (SW'(rcol[1])   << 1) + SW'(rcol[2]);
    assign sx_l = SW'(win[0][0]) + (SW'(win[1][0]) << 1) + SW'(win[2][0]);
    assign sy_b = SW'(win[2][0]) + (SW'(win[2][1]) << 1) + SW'(rcol[2]);
    assign sy_t = SW'(win[0][0]) + (SW'(win[0][1]) << 1) + SW'(rcol[0]);
    assign gx   = $signed(GW'(sx_r)) - $signed(GW'(sx_l));
    assign gy   = $signed(GW'(sy_b)) - $signed(GW'(sy_t));
    assign ax   = gx[GW-1] ? MW'(-gx) : MW'(gx);
    assign ay   = gy[GW-1] ? MW'(-gy) : MW'(gy);
    assign mag  = ax + ay;

    assign border   = (orow == '0) || (orow == RW'(IMG_H-1)) || (ocol == '0) || (ocol == CW'(IMG_W-1));
    assign pix_edge = border ? '0 : ((mag[MW-1:PIX_W] != '0) ? '1 : mag[PIX_W-1:0]);

    // Output pixel selection by the frame's latched mode.
    always_comb begin
        pix_new = '0;
        case (mode_q)
            MODE_MAG:    pix_new = pix_edge;
            MODE_THRESH: pix_new = (!border && (mag >= MW'(thr_q))) ? '1 : '0;
            MODE_GRAY:   pix_new = win[1][1];
            default:     pix_new = pix_edge;
        endcase
    end

    // Next-state logic for the fill / run / flush sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (acc && irow == RW'(1) && icol == '0) state_nxt = RUN;
            RUN:     if (acc && irow == RW'(IMG_H-1) && icol == CW'(IMG_W-1)) state_nxt = FLUSH;
            FLUSH:   if (out_done && out_free) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // State, counters, config latch and window shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            icol   <= '0;
            irow   <= '0;
            ocol   <= '0;
            orow   <= '0;
            ptr    <= '0;
            mode_q <= '0;
            thr_q  <= '0;
            win    <= '0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                if (icol == '0 && irow == '0) begin
                    mode_q <= cfg_mode;
                    thr_q  <= cfg_thresh;
                end
                icol <= (icol == CW'(IMG_W-1)) ? '0 : icol + CW'(1);
                if (icol == CW'(IMG_W-1))
                    irow <= (irow == RW'(IMG_H-1)) ? '0 : irow + RW'(1);
            end
            if (emit) begin
                ocol <= (ocol == CW'(IMG_W-1)) ? '0 : ocol + CW'(1);
                if (ocol == CW'(IMG_W-1))
                    orow <= (orow == RW'(IMG_H-1)) ? '0 : orow + RW'(1);
            end
            if (adv) begin
                ptr <= (ptr == CW'(IMG_W-2)) ? '0 : ptr + CW'(1);
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= rcol[r];
                end
            end
        end
    end

    // Single output stage; holds its contents while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pix   <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
        end else if (emit) begin
            m_valid <= 1'b1;
            m_pix   <= pix_new;
            m_sof   <= out_done;
            m_eol   <= (ocol == CW'(IMG_W-1));
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on a small frame.
module tb_sobel_stream;

    localparam int IMG_W = 10;
    localparam int IMG_H = 6;
    localparam int PIX_W = 8;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int MAXV  = (1 << PIX_W) - 1;

    typedef struct {
        int pix;
        int sof;
        int eol;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid, s_ready;
    logic [PIX_W-1:0] s_r, s_g, s_b;
    logic             m_valid, m_ready;
    logic [PIX_W-1:0] m_pix;
    logic             m_sof, m_eol;
    logic [1:0]       cfg_mode;
    logic [PIX_W-1:0] cfg_thresh;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   out_cnt = 0;
    bit   bp_en = 1'b0;
    bit   mon_ignore = 1'b0;
    bit   stall_pend = 1'b0;
    int   held_pix, held_flags;

    sobel_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_r        (s_r),
        .s_g        (s_g),
        .s_b        (s_b),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_pix      (m_pix),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gray_m(input int r, input int g, input int b);
        int s;
        s = r/4 + r/32 + g/2 + g/16 + b/16 + b/32;
        return (s > MAXV) ? MAXV : s;
    endfunction

    // 0 uniform mid-gray, 1 vertical step, 2 pure red
    task automatic pat_rgb(input int pat, input int c, output int r, output int g, output int b);
        case (pat)
            0:       begin r = 128; g = 128; b = 128; end
            1:       begin r = (c < IMG_W/2) ? 0 : 255; g = r; b = r; end
            default: begin r = 255; g = 0;   b = 0;   end
        endcase
    endtask

    // Downstream ready: always high, or a coin toss each cycle.
    always @(posedge clk) begin
        #1;
        m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: stall stability and scoreboard pop on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_pix", m_pix, held_pix);
                chk("hold_flags", {m_sof, m_eol}, held_flags);
            end
            stall_pend = m_valid && !m_ready;
            held_pix   = m_pix;
            held_flags = {m_sof, m_eol};
            if (m_valid && m_ready && !mon_ignore) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix", m_pix, e.pix);
                    chk("sof", m_sof, e.sof);
                    chk("eol", m_eol, e.eol);
                end
            end
        end
    end

    task automatic drive_pix(input int r, input int g, input int b);
        int n = 0;
        s_valid = 1'b1;
        s_r = PIX_W'(r);
        s_g = PIX_W'(g);
        s_b = PIX_W'(b);
        @(negedge clk);
        while (!s_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 1000) chk("in_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int pat, input int mode, input int th);
        int gi [IMG_H][IMG_W];
        int rr, gg, bb, gx, gy, mag, n, em;
        exp_t e;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                pat_rgb(pat, c, rr, gg, bb);
                gi[r][c] = gray_m(rr, gg, bb);
            end
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                em = (mode == 3) ? 0 : mode;
                if (em == 2) begin
                    e.pix = gi[r][c];
                end else if (r == 0 || r == IMG_H-1 || c == 0 || c == IMG_W-1) begin
                    e.pix = 0;
                end else begin
                    gx = (gi[r-1][c+1] + 2*gi[r][c+1] + gi[r+1][c+1])
                       - (gi[r-1][c-1] + 2*gi[r][c-1] + gi[r+1][c-1]);
                    gy = (gi[r+1][c-1] + 2*gi[r+1][c] + gi[r+1][c+1])
                       - (gi[r-1][c-1] + 2*gi[r-1][c] + gi[r-1][c+1]);
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                    if (em == 1) e.pix = (mag >= th) ? MAXV : 0;
                    else         e.pix = (mag > MAXV) ? MAXV : mag;
                end
                e.sof = (r == 0 && c == 0) ? 1 : 0;
                e.eol = (c == IMG_W-1) ? 1 : 0;
                exp_q.push_back(e);
            end
        out_cnt    = 0;
        cfg_mode   = 2'(mode);
        cfg_thresh = PIX_W'(th);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                pat_rgb(pat, c, rr, gg, bb);
                drive_pix(rr, gg, bb);
            end
        s_valid = 1'b0;
        n = 0;
        while (out_cnt < NPIX && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("frame_count", out_cnt, NPIX);
        chk("queue_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_r = '0; s_g = '0; s_b = '0;
        m_ready = 1'b1; cfg_mode = 2'd0; cfg_thresh = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_pix", m_pix, 0);
        chk("rst_m_sof", m_sof, 0);
        chk("rst_m_eol", m_eol, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", s_ready, 1);

        run_frame(0, 0, 0);      // uniform, magnitude
        run_frame(1, 0, 0);      // vertical step, magnitude
        run_frame(1, 1, 255);    // step, threshold high
        run_frame(1, 1, 0);      // step, threshold zero
        run_frame(2, 2, 0);      // red, gray passthrough
        run_frame(1, 3, 0);      // reserved mode acts as magnitude
        bp_en = 1'b1;
        run_frame(1, 0, 0);      // step under random backpressure
        run_frame(2, 2, 0);
        bp_en = 1'b0;

        // Partial frame then asynchronous reset.
        mon_ignore = 1'b1;
        cfg_mode = 2'd0;
        for (int i = 0; i < NPIX/2 + 3; i++) drive_pix(255, 255, 255);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_async_valid", m_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_valid", m_valid, 0);
        exp_q.delete();
        mon_ignore = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("midrst_s_ready", s_ready, 1);
        run_frame(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
